asym_fifo: RTL

Parametrised asymmetric-width FIFO: a storage array plus pointer/occupancy control. One port is RATIO lanes wide, the other is one lane wide, and the direction is selectable. It generalises the fixed write-2/read-1 controller to any power-of-two ratio, either conversion direction, explicit occupancy, almost-full and overflow/underflow flags. It sits between bus-width domains on the same clock, e.g. a 32-bit producer feeding an 8-bit UART transmit path.

---
 rtl/asym_fifo_pkg.sv | 15 +
 rtl/asym_fifo_if.sv | 35 +++
 rtl/asym_fifo_ptr_ctrl.sv | 76 +++++++
 rtl/asym_fifo.sv | 63 ++++++
 4 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared types and elaboration helpers for the asymmetric-width FIFO.
// Unit sizes are expressed in narrow lanes throughout.
package asym_fifo_pkg;

    typedef enum logic {WIDE_WR, WIDE_RD} asym_mode_t;

    function automatic int lanes_to_units(int ratio, bit wide);
        return wide ? ratio : 1;
    endfunction

    function automatic int cnt_width(int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/asym_fifo_if.sv
// Producer/consumer bundle of the asymmetric FIFO.
// Port widths follow the conversion direction chosen by WIDE_WRITE.
interface asym_fifo_if
    import asym_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int WIDE_WRITE = 1
);
    localparam int WW = lanes_to_units(RATIO, WIDE_WRITE != 0) * DATA_WIDTH;
    localparam int RW = lanes_to_units(RATIO, WIDE_WRITE == 0) * DATA_WIDTH;

    logic                  wr;
    logic [WW-1:0]         w_data;
    logic                  rd;
    logic [RW-1:0]         r_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  ovf;
    logic                  unf;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, almost_full, count, ovf, unf
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, almost_full, count, ovf, unf
    );

endinterface

// File: rtl/asym_fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for the asymmetric FIFO.
// Flags decode only from the count register; no wr/rd to flag path.
module asym_fifo_ptr_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WU         = 4,
    parameter int RU         = 1,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_acc,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  ovf,
    output logic                  unf
);
    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] WU_C    = CW'(WU);
    localparam logic [CW-1:0] RU_C    = CW'(RU);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_acc;

    assign full        = (DEPTH_C - count_q) < WU_C;
    assign empty       = count_q < RU_C;
    assign almost_full = count_q >= AF_C;

    always_comb begin
        wr_acc   = wr && !full;
        rd_acc   = rd && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(WU);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(RU);
        count_d = count_q + (wr_acc ? WU_C : '0) - (rd_acc ? RU_C : '0);
        ovf_d   = wr && full;
        unf_d   = rd && empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: rtl/asym_fifo.sv
// Asymmetric-width FIFO: lane-addressed storage with wide/narrow muxing.
// Wide words are little-endian; lane 0 is stored and read first.
module asym_fifo
    import asym_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int WIDE_WRITE = 1,
    parameter int AF_THRESH  = 12
) (
    input  logic       clk,
    input  logic       reset,
    asym_fifo_if.slave bus
);
    localparam asym_mode_t MODE = (WIDE_WRITE != 0) ? WIDE_WR : WIDE_RD;
    localparam int WU    = lanes_to_units(RATIO, MODE == WIDE_WR);
    localparam int RU    = lanes_to_units(RATIO, MODE == WIDE_RD);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    asym_fifo_ptr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WU         (WU),
        .RU         (RU),
        .AF_THRESH  (AF_THRESH)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .wr          (bus.wr),
        .rd          (bus.rd),
        .wr_acc      (wr_acc),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (bus.count),
        .full        (bus.full),
        .empty       (bus.empty),
        .almost_full (bus.almost_full),
        .ovf         (bus.ovf),
        .unf         (bus.unf)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < WU; i++) begin
                mem_q[wr_ptr + ADDR_WIDTH'(i)] <= bus.w_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        bus.r_data = '0;
        for (int i = 0; i < RU; i++) begin
            bus.r_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr + ADDR_WIDTH'(i)];
        end
    end

endmodule
